// File: rtl/arm_pkg.sv
// Shared ARM core definitions: ALU command and mode encodings, register index
// width, and the control bundle carried from decode into execute.
package arm_pkg;

    localparam int REG_AW = 4;

    typedef enum logic [3:0] {
        ALU_NOP = 4'b0000,
        ALU_MOV = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_ADC = 4'b0011,
        ALU_SUB = 4'b0100,
        ALU_SBC = 4'b0101,
        ALU_AND = 4'b0110,
        ALU_ORR = 4'b0111,
        ALU_EOR = 4'b1000,
        ALU_MVN = 4'b1001
    } alu_cmd_e;

    typedef enum logic [1:0] {
        MODE_COMPUTE = 2'b00,
        MODE_MEMORY  = 2'b01,
        MODE_BRANCH  = 2'b10
    } mode_e;

    // Carry sits with the control fields so it freezes and flushes with them.
    typedef struct packed {
        logic       valid;
        logic [3:0] exec_cmd;
        logic       mem_read;
        logic       mem_write;
        logic       wb_en;
        logic       b;
        logic       s;
        logic       carry;
    } id_ex_ctrl_t;

    localparam int CTRL_W = $bits(id_ex_ctrl_t);

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset, synchronous clear
// (takes precedence over enable), and load enable.
module pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: qualifies the control unit's raw outputs, then
// registers control and data bundles with flush > freeze > load priority.
module id_ex_stage_reg #(
    parameter int WORD_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [3:0]        exec_cmd_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              wb_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [WORD_W-1:0] pc_in,
    input  logic [WORD_W-1:0] val_rn_in,
    input  logic [WORD_W-1:0] val_rm_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       simm24_in,
    input  logic [REG_AW-1:0] dest_in,
    input  logic [REG_AW-1:0] src1_in,
    input  logic [REG_AW-1:0] src2_in,
    input  logic              carry_in,
    output logic              valid_out,
    output logic [3:0]        exec_cmd_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              wb_en_out,
    output logic              b_out,
    output logic              s_out,
    output logic [WORD_W-1:0] pc_out,
    output logic [WORD_W-1:0] val_rn_out,
    output logic [WORD_W-1:0] val_rm_out,
    output logic              imm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       simm24_out,
    output logic [REG_AW-1:0] dest_out,
    output logic [REG_AW-1:0] src1_out,
    output logic [REG_AW-1:0] src2_out,
    output logic              carry_out,
    output logic [15:0]       stall_cycles_out
);

    import arm_pkg::id_ex_ctrl_t;
    import arm_pkg::CTRL_W;

    localparam int DATA_W = 3 * WORD_W + 1 + 12 + 24 + 3 * REG_AW;

    id_ex_ctrl_t       ctrl_d;
    id_ex_ctrl_t       ctrl_q;
    logic [CTRL_W-1:0] ctrl_q_bits;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    logic [15:0]       stall_cycles_d;
    logic [15:0]       stall_cycles_q;
    logic              load_en;

    assign load_en = ~freeze;

    // The control unit forwards S unconditionally, so memory ops drop it here;
    // a simultaneous read+write request resolves to the read.
    always_comb begin
        ctrl_d           = '0;
        ctrl_d.valid     = valid_in;
        ctrl_d.exec_cmd  = valid_in ? exec_cmd_in : 4'b0000;
        ctrl_d.mem_read  = valid_in & mem_read_in;
        ctrl_d.mem_write = valid_in & mem_write_in & ~mem_read_in;
        ctrl_d.wb_en     = valid_in & wb_en_in;
        ctrl_d.b         = valid_in & b_in;
        ctrl_d.s         = valid_in & s_in & ~mem_read_in & ~mem_write_in;
        ctrl_d.carry     = carry_in;
    end

    always_comb begin
        data_d = {pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
                  simm24_in, dest_in, src1_in, src2_in};
    end

    pipe_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
        .clk   (clk),
        .rst_n (rst),
        .clr   (flush),
        .en    (load_en),
        .d     (ctrl_d),
        .q     (ctrl_q_bits)
    );

    pipe_reg #(.WIDTH(DATA_W)) u_data_reg (
        .clk   (clk),
        .rst_n (rst),
        .clr   (flush),
        .en    (load_en),
        .d     (data_d),
        .q     (data_q)
    );

    assign ctrl_q = id_ex_ctrl_t'(ctrl_q_bits);

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (freeze && !flush && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign valid_out        = ctrl_q.valid;
    assign exec_cmd_out     = ctrl_q.exec_cmd;
    assign mem_read_out     = ctrl_q.mem_read;
    assign mem_write_out    = ctrl_q.mem_write;
    assign wb_en_out        = ctrl_q.wb_en;
    assign b_out            = ctrl_q.b;
    assign s_out            = ctrl_q.s;
    assign carry_out        = ctrl_q.carry;
    assign stall_cycles_out = stall_cycles_q;

    assign {pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
            simm24_out, dest_out, src1_out, src2_out} = data_q;

    illegal_mem_combo: assert property (
        @(posedge clk) disable iff (!rst)
        (valid_in && !flush && !freeze) |-> !(mem_read_in && mem_write_in)
    );

endmodule
